// File: rtl/multicycle_control_unit_if.sv
// Control-unit handshake bundle: opcode and memory-ready inputs,
// datapath selects, strobes and trap status outputs.
interface multicycle_control_unit_if #(
   parameter int OP_W     = 5,
   parameter int ALU_OP_W = 2
);
   logic [OP_W-1:0]     instr_op;
   logic                imem_ready;
   logic                dmem_ready;
   logic                branch_taken;
   logic                imem_req;
   logic                ir_write;
   logic                pc_write;
   logic [1:0]          pc_src;
   logic                dmem_req;
   logic                mem_write;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic                reg_write;
   logic [1:0]          wb_sel;
   logic                instr_done;
   logic                trap;
   logic [1:0]          trap_cause;
   logic [2:0]          state;

   modport master (
      input  instr_op, imem_ready, dmem_ready, branch_taken,
      output imem_req, ir_write, pc_write, pc_src, dmem_req, mem_write,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
             instr_done, trap, trap_cause, state
   );

   modport slave (
      output instr_op, imem_ready, dmem_ready, branch_taken,
      input  imem_req, ir_write, pc_write, pc_src, dmem_req, mem_write,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
             instr_done, trap, trap_cause, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing
// against wait-state memories, with timeout detection and a sticky trap state.
module multicycle_control_unit #(
   parameter int OP_W           = 5,
   parameter int ALU_OP_W       = 2,
   parameter int MEM_TIMEOUT    = 15,
   parameter int SUPPORT_CUSTOM = 0
) (
   input  logic clk,
   input  logic rst,
   multicycle_control_unit_if.master bus
);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [OP_W-1:0] OPC_LOAD    = OP_W'(5'b00000);
   localparam logic [OP_W-1:0] OPC_CUSTOM0 = OP_W'(5'b00010);
   localparam logic [OP_W-1:0] OPC_OP_IMM  = OP_W'(5'b00100);
   localparam logic [OP_W-1:0] OPC_AUIPC   = OP_W'(5'b00101);
   localparam logic [OP_W-1:0] OPC_STORE   = OP_W'(5'b01000);
   localparam logic [OP_W-1:0] OPC_OP      = OP_W'(5'b01100);
   localparam logic [OP_W-1:0] OPC_LUI     = OP_W'(5'b01101);
   localparam logic [OP_W-1:0] OPC_BRANCH  = OP_W'(5'b11000);
   localparam logic [OP_W-1:0] OPC_JALR    = OP_W'(5'b11001);
   localparam logic [OP_W-1:0] OPC_JAL     = OP_W'(5'b11011);
   localparam logic [OP_W-1:0] OPC_SYSTEM  = OP_W'(5'b11100);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'b00);
   localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(2'b01);
   localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2'b10);
   localparam logic [ALU_OP_W-1:0] ALU_I   = ALU_OP_W'(2'b11);

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t              state_reg, state_next;
   logic [OP_W-1:0]     op_reg, op_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [1:0]          cause_reg, cause_next;
   logic                timeout_hit;
   logic [CNT_W-1:0]    cnt_inc;
   logic [1:0]          ex_src_a, ex_src_b;
   logic [ALU_OP_W-1:0] ex_alu_op;

   function automatic logic op_executes(input logic [OP_W-1:0] op);
      case (op)
         OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL,
         OPC_OP_IMM, OPC_OP, OPC_AUIPC, OPC_LUI: return 1'b1;
         OPC_CUSTOM0: return (SUPPORT_CUSTOM != 0);
         default: return 1'b0;
      endcase
   endfunction

   // Counter holds the number of wait cycles already spent; saturates when timeout is disabled.
   assign timeout_hit = (MEM_TIMEOUT > 0) && (cnt_reg == CNT_W'(MEM_TIMEOUT));
   assign cnt_inc     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_FETCH;
         op_reg    <= '0;
         cnt_reg   <= '0;
         cause_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         cause_reg <= cause_next;
      end
   end

   // Any transition clears the wait counter, so it restarts on every entry to FETCH or MEM.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = '0;
      cause_next = cause_reg;
      case (state_reg)
         S_FETCH: begin
            if (bus.imem_ready) begin
               state_next = S_DECODE;
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         S_DECODE: begin
            op_next = bus.instr_op;
            if (op_executes(bus.instr_op)) begin
               state_next = S_EXEC;
            end else begin
               state_next = S_TRAP;
               cause_next = (bus.instr_op == OPC_SYSTEM) ? CAUSE_SYSTEM : CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            case (op_reg)
               OPC_LOAD, OPC_STORE:           state_next = S_MEM;
               OPC_BRANCH, OPC_JAL, OPC_JALR: state_next = S_FETCH;
               default:                       state_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (bus.dmem_ready) begin
               state_next = (op_reg == OPC_LOAD) ? S_WB : S_FETCH;
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         S_WB:    state_next = S_FETCH;
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_FETCH;
      endcase
   end

   // ALU operand/op selection for the latched opcode; WB reuses it so the result stays stable.
   always_comb begin
      ex_src_a  = 2'b00;
      ex_src_b  = 2'b00;
      ex_alu_op = ALU_ADD;
      case (op_reg)
         OPC_BRANCH: ex_alu_op = ALU_BR;
         OPC_JAL, OPC_AUIPC: begin
            ex_src_a = 2'b01;
            ex_src_b = 2'b01;
         end
         OPC_JALR, OPC_LOAD, OPC_STORE: ex_src_b = 2'b01;
         OPC_OP, OPC_CUSTOM0: ex_alu_op = ALU_R;
         OPC_OP_IMM: begin
            ex_src_b  = 2'b01;
            ex_alu_op = ALU_I;
         end
         OPC_LUI: begin
            ex_src_a = 2'b10;
            ex_src_b = 2'b01;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.imem_req   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'b00;
      bus.dmem_req   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = ALU_ADD;
      bus.reg_write  = 1'b0;
      bus.wb_sel     = 2'b00;
      bus.instr_done = 1'b0;
      bus.trap       = 1'b0;
      bus.trap_cause = 2'b00;
      bus.state      = 3'd0;
      if (!rst) begin
         bus.state      = state_reg;
         bus.trap_cause = cause_reg;
         case (state_reg)
            S_FETCH: begin
               bus.imem_req  = 1'b1;
               bus.alu_src_a = 2'b01;
               bus.alu_src_b = 2'b10;
               bus.ir_write  = bus.imem_ready;
               bus.pc_write  = bus.imem_ready;
            end
            S_DECODE: begin
               // Branch target pc+imm is formed here while the compare runs in EXEC.
               bus.alu_src_a = 2'b01;
               bus.alu_src_b = 2'b01;
            end
            S_EXEC: begin
               bus.alu_src_a = ex_src_a;
               bus.alu_src_b = ex_src_b;
               bus.alu_op    = ex_alu_op;
               case (op_reg)
                  OPC_BRANCH: begin
                     bus.pc_src     = 2'b01;
                     bus.pc_write   = bus.branch_taken;
                     bus.instr_done = 1'b1;
                  end
                  OPC_JAL, OPC_JALR: begin
                     bus.pc_src     = (op_reg == OPC_JALR) ? 2'b10 : 2'b01;
                     bus.pc_write   = 1'b1;
                     bus.reg_write  = 1'b1;
                     bus.wb_sel     = 2'b10;
                     bus.instr_done = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               bus.dmem_req   = 1'b1;
               bus.mem_write  = (op_reg == OPC_STORE);
               bus.instr_done = (op_reg == OPC_STORE) && bus.dmem_ready;
            end
            S_WB: begin
               bus.alu_src_a  = ex_src_a;
               bus.alu_src_b  = ex_src_b;
               bus.alu_op     = ex_alu_op;
               bus.reg_write  = 1'b1;
               bus.wb_sel     = (op_reg == OPC_LOAD) ? 2'b01 : 2'b00;
               bus.instr_done = 1'b1;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Next-generation RV32I control unit. It replaces the single-cycle combinational opcode decode with a multi-cycle FSM. The FSM sequences fetch, decode, execute, memory and writeback, and handshakes with instruction and data memories that may insert wait states. It sits between the instruction register / memory interfaces and the datapath muxes, ALU control, register file and PC register. It adds JAL/JALR/LUI/AUIPC support, memory-timeout detection and a trap state.

Parameters:
OP_W, 5, opcode field width (instr[6:2]).
ALU_OP_W, 2, width of alu_op to the ALU control decoder.
MEM_TIMEOUT, 15, max wait cycles on imem/dmem before trapping; 0 disables timeout.
SUPPORT_CUSTOM, 0, 1 = CUSTOM0 (5'b00010) executes as R-type; 0 = illegal.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
instr_op  in  OP_W  opcode bits instr[6:2]; valid from DECODE onward (IR output).
imem_ready  in  1  instruction memory has data this cycle.
dmem_ready  in  1  data memory completed access this cycle.
branch_taken  in  1  ALU compare result for current branch.
imem_req  out  1  fetch request.
ir_write  out  1  latch instruction register.
pc_write  out  1  update PC.
pc_src  out  2  00 pc+4, 01 alu_result, 10 alu_result with bit0 cleared.
dmem_req  out  1  data access request.
mem_write  out  1  store when dmem_req=1.
alu_src_a  out  2  00 rs1, 01 pc of current instr, 10 zero.
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
alu_op  out  ALU_OP_W  00 add, 01 branch compare, 10 R-type, 11 I-type.
reg_write  out  1  register file write enable.
wb_sel  out  2  00 alu, 01 mem data, 10 pc+4.
instr_done  out  1  one-cycle pulse on instruction retirement.
trap  out  1  sticky; core halted.
trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 SYSTEM.
state  out  3  current state (debug).

Behaviour:
- rst asserted (any time, including mid-access): state=FETCH, wait counter=0, trap=0, trap_cause=00. All outputs are forced 0 while rst=1. The first imem_req occurs in the first cycle after rst deasserts.
- Unlisted outputs are 0 in each state. Outputs are a combinational function of state, latched opcode and ready/branch_taken inputs.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: imem_req=1, alu_src_a=01, alu_src_b=10, pc_src=00.
  - When imem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: latch instr_op into an internal op register. Opcode routing:
  - LOAD 00000, STORE 01000, BRANCH 11000, JALR 11001, JAL 11011, OP_IMM 00100, OP 01100, AUIPC 00101, LUI 01101 -> EXEC.
  - CUSTOM0 -> EXEC if SUPPORT_CUSTOM=1.
  - SYSTEM 11100 -> TRAP with cause 11.
  - Any other opcode -> TRAP with cause 01.
- EXEC, by opcode:
  - BRANCH: alu_op=01, pc_src=01. pc_write=branch_taken, with target precomputed in DECODE (alu_src_a=01, alu_src_b=01 in DECODE). -> FETCH, instr_done=1.
  - JAL: alu_src_a=01, alu_src_b=01, pc_src=01, pc_write=1, reg_write=1, wb_sel=10 -> FETCH, instr_done=1.
  - JALR: alu_src_a=00, alu_src_b=01, pc_src=10, pc_write=1, reg_write=1, wb_sel=10 -> FETCH, instr_done=1.
  - LOAD/STORE: alu_src_b=01, alu_op=00 -> MEM.
  - OP/CUSTOM0: alu_op=10 -> WB.
  - OP_IMM: alu_src_b=01, alu_op=11 -> WB.
  - LUI: alu_src_a=10, alu_src_b=01 -> WB.
  - AUIPC: alu_src_a=01, alu_src_b=01 -> WB.
- MEM: dmem_req=1, mem_write=1 for STORE. On dmem_ready: LOAD -> WB; STORE -> FETCH with instr_done=1. Otherwise stay in MEM and increment the wait counter.
- WB: reg_write=1, wb_sel=01 for LOAD else 00. The ALU selects of EXEC are held. -> FETCH, instr_done=1.
- Wait counter: cleared on every entry to FETCH or MEM. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with ready still 0, go to TRAP with cause 10. A ready arriving in that same cycle wins over the timeout.
- TRAP: trap=1, all strobes 0. Exit only via rst.
- Zero-wait latencies in cycles (FETCH to the next FETCH): OP/OP_IMM/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3. Each memory wait cycle adds 1.
- No write strobe (reg_write, mem_write, pc_write) is ever asserted in the same cycle as trap=1.

Test Plan:
- Reset mid-MEM: STORE with dmem_ready=0, assert rst -> state=0, all outputs 0, dmem_req drops immediately (async); fetch resumes after release.
- OP (01100), zero wait -> instr_done after 4 cycles; exactly one reg_write cycle, with wb_sel=00 and alu_op=10.
- LOAD, dmem_ready delayed 3 cycles -> 8-cycle instruction; reg_write only in WB, with wb_sel=01; mem_write never asserted.
- BRANCH with branch_taken=0 then 1 -> pc_write 0 then 1 in EXEC (pc_src=01); 3 cycles each; JALR asserts pc_src=10, wb_sel=10 and reg_write in the same cycle.
- imem_ready stuck 0, MEM_TIMEOUT=15 -> TRAP after counter hits 15, trap_cause=10; ready=1 on the deciding cycle instead -> normal DECODE, no trap.
- Opcode 00010 with SUPPORT_CUSTOM=0 -> trap_cause=01; with 1 -> executes as R-type. Opcode 11100 -> trap_cause=11; trap stays 1 until rst.
